uart_tx_scheduler: RTL and testbench

//  Shares the UART byte transmitter between two N-bit result producers
//  (RSA result path, status/ack path) and sends each accepted word as N/8

---
 rtl/uart_tx_scheduler.sv | 115 +++++++++++
 tb/tb_uart_tx_scheduler.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
// Arbitrates two N-bit result producers onto a single UART byte transmitter,
// sending each accepted word MSB byte first with one tx_valid pulse per byte.
module uart_tx_scheduler #(
    parameter int N     = 256,
    parameter int CNT_W = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    input  logic [N-1:0] req0_data,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [N-1:0] req1_data,
    output logic         req1_ready,
    output logic [7:0]   tx_byte,
    output logic         tx_valid,
    input  logic         is_transmitting,
    output logic         busy,
    output logic         done,
    output logic         done_id
);
    localparam int NB = N / 8;

    typedef enum logic [1:0] {IDLE, SEND, WAIT_HI, WAIT_LO} state_t;

    state_t           state, state_nxt;
    logic [N-1:0]     shreg, shreg_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             last_grant, last_grant_nxt;
    logic [7:0]       tx_byte_nxt;
    logic             tx_valid_nxt, busy_nxt, done_nxt, done_id_nxt;
    logic             grant;

    // On a tie the requester that did not win last time is served.
    always_comb begin
        if (req0_valid && req1_valid) grant = ~last_grant;
        else                          grant = req1_valid;
    end

    assign req0_ready = (state == IDLE) && !grant && req0_valid;
    assign req1_ready = (state == IDLE) &&  grant && req1_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            shreg      <= '0;
            cnt        <= '0;
            last_grant <= 1'b1;
            tx_byte    <= 8'h00;
            tx_valid   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            done_id    <= 1'b0;
        end else begin
            state      <= state_nxt;
            shreg      <= shreg_nxt;
            cnt        <= cnt_nxt;
            last_grant <= last_grant_nxt;
            tx_byte    <= tx_byte_nxt;
            tx_valid   <= tx_valid_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            done_id    <= done_id_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        shreg_nxt      = shreg;
        cnt_nxt        = cnt;
        last_grant_nxt = last_grant;
        tx_byte_nxt    = tx_byte;
        tx_valid_nxt   = 1'b0;
        busy_nxt       = busy;
        done_nxt       = 1'b0;
        done_id_nxt    = done_id;
        case (state)
            IDLE: begin
                if (req0_ready || req1_ready) begin
                    shreg_nxt      = grant ? req1_data : req0_data;
                    cnt_nxt        = CNT_W'(NB);
                    last_grant_nxt = grant;
                    busy_nxt       = 1'b1;
                    state_nxt      = SEND;
                end
            end
            SEND: begin
                // Never start a byte while the UART is still busy.
                if (!is_transmitting) begin
                    tx_byte_nxt  = shreg[N-1 -: 8];
                    tx_valid_nxt = 1'b1;
                    shreg_nxt    = shreg << 8;
                    state_nxt    = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (is_transmitting) state_nxt = WAIT_LO;
            end
            WAIT_LO: begin
                if (!is_transmitting) begin
                    cnt_nxt = cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        done_nxt    = 1'b1;
                        done_id_nxt = last_grant;
                        busy_nxt    = 1'b0;
                        state_nxt   = IDLE;
                    end else begin
                        state_nxt = SEND;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: a 256-bit instance for the main scenarios and a
// 16-bit instance for short back-to-back words, each driving a simple UART model.
module tb_uart_tx_scheduler;
    localparam int UART_D = 10;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         ext_busy = 1'b0;
    int           cyc = 0;
    int           checks = 0;
    int           failures = 0;

    logic         a_r0v = 0, a_r1v = 0, a_r0, a_r1, a_txv, a_it, a_busy, a_done, a_did;
    logic [255:0] a_d0 = '0, a_d1 = '0;
    logic [7:0]   a_txb;
    logic         b_r0v = 0, b_r1v = 0, b_r0, b_r1, b_txv, b_it, b_busy, b_done, b_did;
    logic [15:0]  b_d0 = '0, b_d1 = '0;
    logic [7:0]   b_txb;
    int           ucnt_a = 0, ucnt_b = 0;

    uart_tx_scheduler #(.N(256), .CNT_W(6)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(a_r0v), .req0_data(a_d0), .req0_ready(a_r0),
        .req1_valid(a_r1v), .req1_data(a_d1), .req1_ready(a_r1),
        .tx_byte(a_txb), .tx_valid(a_txv), .is_transmitting(a_it),
        .busy(a_busy), .done(a_done), .done_id(a_did));

    uart_tx_scheduler #(.N(16), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(b_r0v), .req0_data(b_d0), .req0_ready(b_r0),
        .req1_valid(b_r1v), .req1_data(b_d1), .req1_ready(b_r1),
        .tx_byte(b_txb), .tx_valid(b_txv), .is_transmitting(b_it),
        .busy(b_busy), .done(b_done), .done_id(b_did));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // UART: busy for UART_D cycles after each start pulse
    always @(posedge clk) begin
        if (a_txv) ucnt_a <= UART_D; else if (ucnt_a != 0) ucnt_a <= ucnt_a - 1;
        if (b_txv) ucnt_b <= UART_D; else if (ucnt_b != 0) ucnt_b <= ucnt_b - 1;
    end
    assign a_it = (ucnt_a != 0) || ext_busy;
    assign b_it = (ucnt_b != 0);

    // Word-level model: one word in flight per instance, bytes MSB first
    bit           inflight[2], mlast[2], cur_id[2], prev_txv[2], prev_it[2];
    logic [255:0] cur_word[2];
    int           nbk[2] = '{32, 2};
    int           sent[2], nacc[2], ndone[2], acc_cyc[2], first_tx[2], rdy_in_done[2];
    logic [7:0]   blog[$], blog_b[$];
    int           tlog_b[$];
    bit           did_log[$];

    task automatic chk(input string name, input int k, input logic [255:0] act,
                       input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] got=%0h want=%0h", name, k, act, exp);
        end
    endtask

    task automatic sample(input int k, input logic r0v, r1v, input logic [255:0] d0, d1,
                          input logic r0, r1, txv, input logic [7:0] txb,
                          input logic it, bsy, dn, did);
        logic e0, e1;
        logic [7:0] eb;
        if (!rst_n) begin
            chk("reset_out", k, {txb, txv, bsy, dn, did, r0, r1}, 0);
            inflight[k] = 0; mlast[k] = 1; sent[k] = 0;
            prev_txv[k] = 0; prev_it[k] = it;
            return;
        end
        if (dn) begin
            chk("done_unexpected", k, inflight[k], 1);
            chk("done_id", k, did, cur_id[k]);
            chk("done_all_bytes", k, sent[k], nbk[k]);
            if (k == 0) did_log.push_back(did);
            if (r0 || r1) rdy_in_done[k]++;
            ndone[k]++;
            inflight[k] = 0;
        end
        chk("busy", k, bsy, inflight[k]);
        if (txv) begin
            chk("tx_while_uart_busy", k, prev_it[k], 0);
            chk("tx_pulse_width", k, prev_txv[k], 0);
            chk("tx_in_word", k, inflight[k] && sent[k] < nbk[k], 1);
            eb = 8'(cur_word[k] >> (8 * (nbk[k] - 1 - sent[k])));
            chk("tx_byte", k, txb, eb);
            if (sent[k] == 0) first_tx[k] = cyc;
            sent[k]++;
            if (k == 0) blog.push_back(txb);
            else begin blog_b.push_back(txb); tlog_b.push_back(cyc); end
        end else if (inflight[k] && sent[k] > 0) begin
            eb = 8'(cur_word[k] >> (8 * (nbk[k] - sent[k])));
            chk("tx_byte_hold", k, txb, eb);
        end
        e0 = !inflight[k] && r0v && (!r1v || mlast[k]);
        e1 = !inflight[k] && r1v && (!r0v || !mlast[k]);
        chk("req0_ready", k, r0, e0);
        chk("req1_ready", k, r1, e1);
        if (e0 || e1) begin
            inflight[k] = 1; mlast[k] = e1; cur_id[k] = e1;
            cur_word[k] = e1 ? d1 : d0; sent[k] = 0;
            acc_cyc[k] = cyc; nacc[k]++;
        end
        prev_txv[k] = txv; prev_it[k] = it;
    endtask

    always @(negedge clk) begin
        sample(0, a_r0v, a_r1v, a_d0, a_d1, a_r0, a_r1, a_txv, a_txb, a_it, a_busy, a_done, a_did);
        sample(1, b_r0v, b_r1v, 256'(b_d0), 256'(b_d1), b_r0, b_r1, b_txv, b_txb, b_it,
               b_busy, b_done, b_did);
    end

    function automatic logic [255:0] mkword(input logic [7:0] base);
        logic [255:0] w = '0;
        for (int i = 0; i < 32; i++) w = {w[247:0], 8'(base + 8'(i))};
        return w;
    endfunction

    task automatic wait_acc(input int k, input int target, input int budget, input string name);
        int n = 0;
        while (nacc[k] < target && n < budget) begin @(posedge clk); n++; end
        #1;
        chk(name, k, nacc[k], target);
    endtask

    task automatic wait_done(input int k, input int target, input int budget, input string name);
        int n = 0;
        while (ndone[k] < target && n < budget) begin @(posedge clk); n++; end
        #1;
        chk(name, k, ndone[k], target);
    endtask

    task automatic do_reset();
        rst_n = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
    endtask

    initial begin
        int base_a, base_d, drop, n;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", 0, {a_txb, a_txv, a_busy, a_done, a_did, a_r0, a_r1}, 0);
        rst_n = 1;

        // 1: single 32-byte word from requester 0
        blog.delete(); did_log.delete();
        a_d0 = mkword(8'h01); a_r0v = 1;
        wait_acc(0, 1, 20, "t1_accept");
        a_r0v = 0;
        wait_done(0, 1, 1000, "t1_done");
        chk("t1_nbytes", 0, blog.size(), 32);
        for (int i = 0; i < 32; i++) chk("t1_byte", i, blog[i], 8'(i + 1));
        chk("t1_done_cnt", 0, did_log.size(), 1);
        chk("t1_done_id", 0, did_log[0], 0);
        chk("t1_latency", 0, first_tx[0] - acc_cyc[0], 2);

        // 2: both requesters continuously valid from reset
        do_reset();
        blog.delete(); did_log.delete();
        base_a = nacc[0]; base_d = ndone[0];
        a_d0 = mkword(8'h01); a_d1 = mkword(8'h81); a_r0v = 1; a_r1v = 1;
        wait_acc(0, base_a + 3, 2000, "t2_accept");
        a_r0v = 0; a_r1v = 0;
        wait_done(0, base_d + 3, 2000, "t2_done");
        chk("t2_done_cnt", 0, did_log.size(), 3);
        chk("t2_id0", 0, did_log[0], 0);
        chk("t2_id1", 0, did_log[1], 1);
        chk("t2_id2", 0, did_log[2], 0);
        chk("t2_nbytes", 0, blog.size(), 96);
        chk("t2_b0", 0, blog[0], 8'h01);
        chk("t2_b32", 0, blog[32], 8'h81);
        chk("t2_b63", 0, blog[63], 8'hA0);
        chk("t2_b64", 0, blog[64], 8'h01);

        // 3: UART busy at acceptance for 50 cycles
        repeat (5) @(posedge clk);
        #1;
        blog.delete();
        base_a = nacc[0]; base_d = ndone[0];
        ext_busy = 1; a_d0 = mkword(8'h21); a_r0v = 1;
        wait_acc(0, base_a + 1, 20, "t3_accept");
        a_r0v = 0;
        repeat (49) @(posedge clk);
        #1;
        chk("t3_no_tx_while_busy", 0, blog.size(), 0);
        ext_busy = 0; drop = cyc;
        wait_done(0, base_d + 1, 1000, "t3_done");
        chk("t3_first_after_drop", 0, first_tx[0] - drop, 1);
        chk("t3_b0", 0, blog[0], 8'h21);

        // 4: reset in the middle of a word
        blog.delete();
        base_a = nacc[0];
        a_d0 = mkword(8'h41); a_r0v = 1;
        wait_acc(0, base_a + 1, 20, "t4_accept");
        a_r0v = 0;
        n = 0;
        while (blog.size() < 5 && n < 200) begin @(posedge clk); n++; end
        chk("t4_five_bytes", 0, blog.size(), 5);
        #1 rst_n = 0;
        #1;
        chk("t4_reset_out", 0, {a_txb, a_txv, a_busy, a_done, a_did, a_r0, a_r1}, 0);
        base_d = ndone[0];
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        chk("t4_no_done", 0, ndone[0], base_d);
        blog.delete();
        base_a = nacc[0];
        a_d0 = mkword(8'hC0); a_r0v = 1;
        wait_acc(0, base_a + 1, 20, "t4_accept2");
        a_r0v = 0;
        wait_done(0, base_d + 1, 1000, "t4_done");
        chk("t4_nbytes", 0, blog.size(), 32);
        chk("t4_b0", 0, blog[0], 8'hC0);
        chk("t4_b31", 0, blog[31], 8'hDF);

        // 5: requester 1 data changes after acceptance
        blog.delete();
        base_a = nacc[0]; base_d = ndone[0];
        a_d1 = mkword(8'h60); a_r1v = 1;
        wait_acc(0, base_a + 1, 20, "t5_accept");
        a_d1 = mkword(8'hE0); a_r1v = 0;
        wait_done(0, base_d + 1, 1000, "t5_done");
        chk("t5_b0", 0, blog[0], 8'h60);
        chk("t5_b31", 0, blog[31], 8'h7F);
        chk("t5_done_id", 0, did_log[did_log.size() - 1], 1);

        // 6: 16-bit words back to back
        base_a = nacc[1]; base_d = ndone[1];
        b_d0 = 16'h5AC3; b_r0v = 1;
        wait_acc(1, base_a + 3, 200, "t6_accept");
        b_r0v = 0;
        wait_done(1, base_d + 3, 200, "t6_done");
        chk("t6_nbytes", 1, blog_b.size(), 6);
        for (int i = 0; i < 6; i++) chk("t6_byte", i, blog_b[i], (i % 2) ? 8'hC3 : 8'h5A);
        chk("t6_gap_in_word", 1, tlog_b[1] - tlog_b[0], UART_D + 3);
        chk("t6_gap_across_words", 1, tlog_b[2] - tlog_b[1], UART_D + 4);
        chk("t6_gap_in_word2", 1, tlog_b[3] - tlog_b[2], UART_D + 3);
        chk("t6_ready_in_done", 1, rdy_in_done[1], 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
